// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis helpers, index widths and FSM state type for the Viterbi decoder
package viterbi_pkg;
  localparam int K_MAX = 7;
  localparam int SW_MAX = K_MAX - 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  function automatic logic [1:0] enc_out(input logic [SW_MAX:0] r, input logic [SW_MAX:0] g0, input logic [SW_MAX:0] g1);
    return {^(r & g0), ^(r & g1)};
  endfunction
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    return 2'(a[1] ^ b[1]) + 2'(a[0] ^ b[0]);
  endfunction
endpackage

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select for one next state, ties resolved to the even predecessor
// Ports: pm0_i/pm1_i predecessor metrics, bm0_i/bm1_i branch metrics, sv0_i/sv1_i predecessor
// survivors, u_i decided input bit; pm_o/sv_o selected metric and extended survivor.
module viterbi_acs_unit #(
  parameter int PM_W = 8,
  parameter int TB_DEPTH = 15
) (
  input  logic [PM_W-1:0]     pm0_i,
  input  logic [PM_W-1:0]     pm1_i,
  input  logic [1:0]          bm0_i,
  input  logic [1:0]          bm1_i,
  input  logic [TB_DEPTH-1:0] sv0_i,
  input  logic [TB_DEPTH-1:0] sv1_i,
  input  logic                u_i,
  output logic [PM_W-1:0]     pm_o,
  output logic [TB_DEPTH-1:0] sv_o
);
  logic [PM_W-1:0] c0, c1;
  logic sel;
  always_comb begin
    c0 = pm0_i + PM_W'(bm0_i);
    c1 = pm1_i + PM_W'(bm1_i);
    sel = c1 < c0;
    pm_o = sel ? c1 : c0;
    sv_o = ((sel ? sv1_i : sv0_i) << 1) | TB_DEPTH'(u_i);
  end
endmodule

// File: rtl/viterbi_dec_param.sv
// viterbi_dec_param: parametrised hard-decision rate-1/2 Viterbi decoder with register-exchange survivors
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_sym/in_sof/in_eof symbol handshake;
// cfg_term flushes from state 0; out_valid/out_bit/out_last decoded stream; err protocol-error pulse.
module viterbi_dec_param
  import viterbi_pkg::*;
#(
  parameter int K = 3,
  parameter int G0 = 'o7,
  parameter int G1 = 'o5,
  parameter int TB_DEPTH = 15,
  parameter int PM_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       cfg_term,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       err
);
  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int FW = $clog2(TB_DEPTH + 1);
  state_e state_q, state_d;
  logic [PM_W-1:0] pm_q [NS], pm_d [NS], pm_old [NS], pm_acs [NS];
  logic [TB_DEPTH-1:0] surv_q [NS], surv_d [NS], sv_old [NS], sv_acs [NS];
  logic [FW-1:0] fill_q, fill_d, fill_n, pend_q, pend_d;
  logic [SW-1:0] fs_q, fs_d, best;
  logic [PM_W-1:0] best_pm;
  logic wait_q, wait_d, emit_q, emit_d, in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d, err_q, err_d;
  logic acc, init, upd, all_msb;
  assign acc = in_valid & in_ready_q;
  assign init = acc & in_sof;
  assign upd = acc & (in_sof | (state_q == RUN));
  // a start-of-frame symbol is decoded against freshly initialised metrics in the same update
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      pm_old[i] = init ? (i == 0 ? '0 : PM_W'(2 * K)) : pm_q[i];
      sv_old[i] = init ? '0 : surv_q[i];
    end
  end
  for (genvar n = 0; n < NS; n++) begin : g_acs
    localparam int P0 = (2 * n) % NS;
    localparam int U = n >> (K - 2);
    localparam logic [1:0] E0 = enc_out(K_MAX'((U << (K - 1)) | P0), K_MAX'(G0), K_MAX'(G1));
    localparam logic [1:0] E1 = enc_out(K_MAX'((U << (K - 1)) | (P0 + 1)), K_MAX'(G0), K_MAX'(G1));
    viterbi_acs_unit #(.PM_W(PM_W), .TB_DEPTH(TB_DEPTH)) u_acs (
      .pm0_i(pm_old[P0]),
      .pm1_i(pm_old[P0+1]),
      .bm0_i(hamming2(in_sym, E0)),
      .bm1_i(hamming2(in_sym, E1)),
      .sv0_i(sv_old[P0]),
      .sv1_i(sv_old[P0+1]),
      .u_i(1'(U)),
      .pm_o(pm_acs[n]),
      .sv_o(sv_acs[n])
    );
  end
  // subtract half the metric range from every state once all of them have crossed it
  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS; i++) all_msb &= pm_acs[i][PM_W-1];
    for (int i = 0; i < NS; i++) begin
      pm_d[i] = upd ? {pm_acs[i][PM_W-1] & ~all_msb, pm_acs[i][PM_W-2:0]} : pm_q[i];
      surv_d[i] = upd ? sv_acs[i] : surv_q[i];
    end
  end
  always_comb begin
    best = '0;
    best_pm = pm_q[0];
    for (int i = 1; i < NS; i++) begin
      if (pm_q[i] < best_pm) begin
        best = SW'(i);
        best_pm = pm_q[i];
      end
    end
  end
  always_comb begin
    fill_n = init ? FW'(1) : (fill_q == FW'(TB_DEPTH) ? fill_q : fill_q + FW'(1));
    state_d = state_q;
    fill_d = upd ? fill_n : fill_q;
    pend_d = pend_q;
    fs_d = fs_q;
    wait_d = 1'b0;
    emit_d = upd & (fill_n == FW'(TB_DEPTH));
    out_valid_d = emit_q;
    out_bit_d = emit_q & surv_q[best][TB_DEPTH-1];
    out_last_d = 1'b0;
    err_d = acc & (state_q == RUN ? in_sof : ~in_sof);
    if (upd) begin
      state_d = in_eof ? FLUSH : RUN;
      wait_d = in_eof;
      pend_d = in_eof ? (fill_n < FW'(TB_DEPTH) ? fill_n : FW'(TB_DEPTH - 1)) : pend_q;
    end
    // the wait cycle lets the final run emission drain and sees the metrics of the last symbol
    if (state_q == FLUSH && wait_q) fs_d = cfg_term ? '0 : best;
    if (state_q == FLUSH && !wait_q) begin
      out_valid_d = 1'b1;
      out_bit_d = |(surv_q[fs_q] & (TB_DEPTH'(1) << (pend_q - FW'(1))));
      pend_d = pend_q - FW'(1);
      out_last_d = pend_q == FW'(1);
      state_d = pend_q == FW'(1) ? IDLE : FLUSH;
    end
    in_ready_d = state_d != FLUSH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NS; i++) begin
        pm_q[i] <= '0;
        surv_q[i] <= '0;
      end
      fill_q <= '0;
      pend_q <= '0;
      fs_q <= '0;
      wait_q <= 1'b0;
      emit_q <= 1'b0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q <= 1'b0;
      out_last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pm_q <= pm_d;
      surv_q <= surv_d;
      fill_q <= fill_d;
      pend_q <= pend_d;
      fs_q <= fs_d;
      wait_q <= wait_d;
      emit_q <= emit_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q <= out_bit_d;
      out_last_q <= out_last_d;
      err_q <= err_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit = out_bit_q;
  assign out_last = out_last_q;
  assign err = err_q;
endmodule

// File: tb/tb_viterbi_dec_param.sv
// tb_viterbi_dec_param: directed checks of the K=3 (7/5) and K=7 (171/133) decoder configurations
module tb_viterbi_dec_param;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v3 = 1'b0, v7 = 1'b0, sof = 1'b0, eof = 1'b0, term = 1'b1;
  logic [1:0] sym = '0;
  logic rdy3, ov3, ob3, ol3, err3, rdy7, ov7, ob7, ol7, err7;
  int checks = 0, errors = 0, errs = 0, rlow3 = 0;
  bit q3[$], l3[$], q7[$], l7[$], msg[$];
  time t_acc = 0, t_first = 0, t_last = 0;
  logic [1:0] fa [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
  always #5 clk = ~clk;
  viterbi_dec_param dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3), .in_sym(sym), .in_sof(sof),
    .in_eof(eof), .cfg_term(term), .out_valid(ov3), .out_bit(ob3), .out_last(ol3), .err(err3)
  );
  viterbi_dec_param #(.K(7), .G0('o171), .G1('o133), .TB_DEPTH(35), .PM_W(8)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(v7), .in_ready(rdy7), .in_sym(sym), .in_sof(sof),
    .in_eof(eof), .cfg_term(term), .out_valid(ov7), .out_bit(ob7), .out_last(ol7), .err(err7)
  );
  always @(negedge clk) begin
    if (ov3) begin
      q3.push_back(ob3);
      l3.push_back(ol3);
      if (t_first == 0) t_first = $time;
    end
    if (ov7) begin
      q7.push_back(ob7);
      l7.push_back(ol7);
    end
    errs += int'(err3 | err7);
    rlow3 += int'(!rdy3);
  end
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] enc(input int k, input int g0, input int g1, input int st, input bit u);
    int r;
    r = (int'(u) << (k - 1)) | st;
    return {^(r & g0), ^(r & g1)};
  endfunction
  function automatic int pack(input bit q[$]);
    int v = 0;
    foreach (q[i]) v = (v << 1) | int'(q[i]);
    return v;
  endfunction
  function automatic int ones(input bit q[$]);
    int v = 0;
    foreach (q[i]) v += int'(q[i]);
    return v;
  endfunction
  function automatic int nmis(input bit q[$], input int m);
    int v = 0;
    for (int i = 0; i < m; i++) if (i >= q.size() || q[i] != msg[i]) v++;
    return v;
  endfunction
  task automatic send(input bit d7, input logic [1:0] s, input bit f, input bit l);
    sym = s;
    sof = f;
    eof = l;
    v3 = !d7;
    v7 = d7;
    @(posedge clk);
    t_last = $time;
    #1;
    v3 = 1'b0;
    v7 = 1'b0;
    sof = 1'b0;
    eof = 1'b0;
  endtask
  task automatic send_msg(input bit d7, input int gap_max, input bit noisy);
    int k, g0, g1, st;
    logic [1:0] s;
    k = d7 ? 7 : 3;
    g0 = d7 ? 'o171 : 'o7;
    g1 = d7 ? 'o133 : 'o5;
    st = 0;
    for (int i = 0; i < msg.size(); i++) begin
      s = enc(k, g0, g1, st, msg[i]);
      if (noisy && i % 50 == 0 && i > 0 && i <= 150) s[1] = ~s[1];
      st = (int'(msg[i]) << (k - 2)) | (st >> 1);
      repeat ($urandom_range(gap_max, 0)) begin
        @(posedge clk);
        #1;
      end
      send(d7, s, i == 0, i == msg.size() - 1);
      if (i == 14) t_acc = t_last;
    end
  endtask
  task automatic wait_out(input string tag, input bit d7, input int n, input int lim);
    int c = 0;
    while ((d7 ? q7.size() : q3.size()) < n && c < lim) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    chk(tag, d7 ? q7.size() : q3.size(), n);
    @(posedge clk);
    #1;
  endtask
  task automatic frame_a(input string tag, input bit bad);
    q3.delete();
    l3.delete();
    rlow3 = 0;
    errs = 0;
    for (int i = 0; i < 6; i++) send(1'b0, (bad && i == 2) ? 2'b10 : fa[i], i == 0, i == 5);
    chk({tag, "_run_quiet"}, q3.size(), 0);
    chk({tag, "_flush_rdy"}, rdy3, 0);
    wait_out({tag, "_count"}, 1'b0, 6, 40);
    chk({tag, "_bits"}, pack(q3), 'b101100);
    chk({tag, "_last"}, pack(l3), 'b000001);
    chk({tag, "_rdy_low"}, rlow3, 7);
    chk({tag, "_err"}, errs, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", ov3, 0);
    chk("rst_rdy", rdy3, 1);
    chk("rst_err", err3, 0);
    chk("rst_last", ol3, 0);
    chk("rst_rdy7", rdy7, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_a("fa", 1'b0);
    frame_a("fb", 1'b1);
    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(1'($urandom_range(1, 0)));
    repeat (2) msg.push_back(1'b0);
    q3.delete();
    l3.delete();
    t_first = 0;
    send_msg(1'b0, 0, 1'b0);
    wait_out("r42_count", 1'b0, 42, 60);
    chk("r42_latency", int'(t_first - t_acc), 15);
    chk("r42_bits", nmis(q3, 40), 0);
    chk("r42_last_pos", int'(l3[41]), 1);
    chk("r42_last_cnt", ones(l3), 1);
    term = 1'b0;
    msg.delete();
    for (int i = 0; i < 200; i++) msg.push_back(1'($urandom_range(1, 0)));
    repeat (6) msg.push_back(1'b0);
    q7.delete();
    l7.delete();
    send_msg(1'b1, 0, 1'b1);
    wait_out("k7_count", 1'b1, 206, 300);
    chk("k7_bits", nmis(q7, 200), 0);
    chk("k7_last_pos", int'(l7[205]), 1);
    term = 1'b1;
    msg.delete();
    for (int i = 0; i < 2000; i++) msg.push_back(1'($urandom_range(1, 0)));
    repeat (2) msg.push_back(1'b0);
    q3.delete();
    l3.delete();
    errs = 0;
    send_msg(1'b0, 2, 1'b0);
    wait_out("long_count", 1'b0, 2002, 100);
    chk("long_bits", nmis(q3, 2002), 0);
    chk("long_last", ones(l3), 1);
    chk("long_err", errs, 0);
    q3.delete();
    l3.delete();
    errs = 0;
    send(1'b0, 2'b11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("nosof_err", errs, 1);
    chk("nosof_out", q3.size(), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) send(1'b0, 2'b00, i == 0, 1'b0);
    chk("pre_rst_ov", ov3, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", ov3, 0);
    chk("mid_rst_rdy", rdy3, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_last", ones(l3), 0);
    frame_a("fc", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
